// File: rtl/cdp_dp_layer_sched.sv
// cdp_dp_layer_sched: gates the RDMA beat stream for one layer at a time and flips the ping-pong consumer.
// Define CDP_LAYER_SCHED_WDOG_EN to enable the idle watchdog.
module cdp_dp_layer_sched #(
    parameter int TP_BITS = 64,
    parameter int CNT_W   = 32
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 rdma_valid,
    output logic                 rdma_ready,
    input  logic [TP_BITS+22:0]  rdma_pd,
    output logic                 dp_valid,
    input  logic                 dp_ready,
    output logic [TP_BITS+22:0]  dp_pd,
    input  logic                 reg2dp_d0_op_en,
    input  logic                 reg2dp_d1_op_en,
    input  logic [15:0]          reg2dp_wdog_limit,
    input  logic                 wdma_done,
    output logic                 dp_op_en,
    output logic                 dp2reg_consumer,
    output logic                 dp2reg_done,
    output logic [1:0]           dp2reg_op_en_clr,
    output logic [CNT_W-1:0]     dp2reg_beat_num,
    output logic                 dp2reg_wdog_err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic cons_q, cons_d, pend_q, pend_d, run, hs, last, wdog_to;
    logic [CNT_W-1:0] cnt_q, cnt_d, beat_q, beat_d;
    assign run = state_q == RUN;
    assign hs = run & rdma_valid & dp_ready;
    assign last = &rdma_pd[TP_BITS+14:TP_BITS+8];
    assign dp_valid = run & rdma_valid;
    assign rdma_ready = run & dp_ready;
    assign dp_pd = rdma_pd;
    assign dp_op_en = run | (state_q == DRAIN);
    assign dp2reg_consumer = cons_q;
    assign dp2reg_done = state_q == DONE;
    assign dp2reg_op_en_clr = {dp2reg_done & cons_q, dp2reg_done & ~cons_q};
    assign dp2reg_beat_num = beat_q;
    always_comb begin
        state_d = state_q;
        cons_d = cons_q;
        pend_d = pend_q;
        cnt_d = cnt_q;
        beat_d = beat_q;
        case (state_q)
            IDLE: if (cons_q ? reg2dp_d1_op_en : reg2dp_d0_op_en) begin
                state_d = RUN;
                cnt_d = '0;
                pend_d = 1'b0;
            end
            RUN: begin
                cnt_d = hs ? cnt_q + 1'b1 : cnt_q;
                pend_d = pend_q | wdma_done;
                state_d = (hs & last) ? DRAIN : RUN;
            end
            DRAIN: state_d = (wdma_done | pend_q) ? DONE : DRAIN;
            DONE: begin
                state_d = IDLE;
                cons_d = ~cons_q;
                beat_d = cnt_q;
            end
            default: state_d = IDLE;
        endcase
        if (wdog_to) state_d = DONE;
    end
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            cons_q <= 1'b0;
            pend_q <= 1'b0;
            cnt_q <= '0;
            beat_q <= '0;
        end else begin
            state_q <= state_d;
            cons_q <= cons_d;
            pend_q <= pend_d;
            cnt_q <= cnt_d;
            beat_q <= beat_d;
        end
    end
`ifdef CDP_LAYER_SCHED_WDOG_EN
    logic [15:0] idle_q, idle_d;
    logic err_q;
    // idle count restarts on any sign of progress or on entering a new state
    assign wdog_to = dp_op_en & (reg2dp_wdog_limit != 16'd0) & (idle_q == reg2dp_wdog_limit);
    assign idle_d = (!dp_op_en || hs || wdma_done || state_d != state_q) ? 16'd0 : idle_q + 16'd1;
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            idle_q <= '0;
            err_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q <= err_q | wdog_to;
        end
    end
    assign dp2reg_wdog_err = err_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^reg2dp_wdog_limit;
    assign wdog_to = 1'b0;
    assign dp2reg_wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_cdp_dp_layer_sched.sv
// tb_cdp_dp_layer_sched: scoreboard bench for the CDP layer sequencer.
module tb_cdp_dp_layer_sched;
    localparam int TP = 64, CW = 32, PW = TP + 23;
    typedef struct {int n; logic grp;} rec_t;
    logic clk = 0, rst = 1, rdma_valid = 0, dp_ready = 1, d0 = 0, d1 = 0, wdma_done = 0;
    logic rdma_ready, dp_valid, dp_op_en, cons, done, wdog_err;
    logic [PW-1:0] rdma_pd = '0, dp_pd;
    logic [15:0] limit = 16'd0;
    logic [1:0] clr;
    logic [CW-1:0] beat_num;
    int checks = 0, errors = 0;
    logic [PW-1:0] exp_pd[$];
    rec_t exp_done[$];

    cdp_dp_layer_sched #(.TP_BITS(TP), .CNT_W(CW)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .rdma_valid(rdma_valid), .rdma_ready(rdma_ready), .rdma_pd(rdma_pd),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_pd(dp_pd),
        .reg2dp_d0_op_en(d0), .reg2dp_d1_op_en(d1), .reg2dp_wdog_limit(limit),
        .wdma_done(wdma_done), .dp_op_en(dp_op_en), .dp2reg_consumer(cons),
        .dp2reg_done(done), .dp2reg_op_en_clr(clr), .dp2reg_beat_num(beat_num),
        .dp2reg_wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    task automatic monitor();
        logic dprev = 0, cexp = 0;
        int nb = 0;
        logic [PW-1:0] e;
        rec_t r;
        forever begin
            @(negedge clk);
            if (rst) dprev = 0;
            else begin
                if (dp_valid && dp_ready) begin
                    checks++;
                    if (exp_pd.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat got pd=%h want no beat", dp_pd);
                    end else begin
                        e = exp_pd.pop_front();
                        if (dp_pd !== e) begin errors++; $display("FAIL dp_pd got %h want %h", dp_pd, e); end
                    end
                end
                if (!dp_op_en) begin
                    checks++;
                    if (dp_valid !== 1'b0 || rdma_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL gate_closed got valid=%b ready=%b want 0 0", dp_valid, rdma_ready);
                    end
                end
                if (done) begin
                    checks++;
                    if (dprev || exp_done.size() == 0) begin
                        errors++;
                        $display("FAIL done_pulse got extra pulse want none");
                    end else begin
                        r = exp_done.pop_front();
                        nb = r.n;
                        cexp = ~r.grp;
                        checks++;
                        if (clr !== (r.grp ? 2'b10 : 2'b01)) begin
                            errors++;
                            $display("FAIL op_en_clr got %b want %b", clr, r.grp ? 2'b10 : 2'b01);
                        end
                    end
                end else begin
                    checks++;
                    if (clr !== 2'b00) begin errors++; $display("FAIL op_en_clr_idle got %b want 00", clr); end
                end
                if (dprev) begin
                    checks++;
                    if (beat_num !== nb) begin errors++; $display("FAIL beat_num got %0d want %0d", beat_num, nb); end
                    checks++;
                    if (cons !== cexp) begin errors++; $display("FAIL consumer got %b want %b", cons, cexp); end
                end
                dprev = done;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input string nm);
        int t = 0;
        @(negedge clk);
        while (!dp_op_en && t < 20) begin @(negedge clk); t++; end
        checks++;
        if (dp_op_en !== 1'b1) begin errors++; $display("FAIL %s_start got dp_op_en=%b want 1", nm, dp_op_en); end
    endtask

    task automatic send_beats(input int n, input bit last, input bit tgl, input bit wsame);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            logic [PW-1:0] pd;
            tick();
            if (tgl) dp_ready = ~dp_ready;
            pd = {$urandom, $urandom, $urandom};
            pd[TP+14:TP+8] = (last && i == n - 1) ? 7'h7f : 7'h00;
            rdma_pd = pd;
            rdma_valid = 1;
            wdma_done = wsame && last && i == n - 1;
            exp_pd.push_back(pd);
            forever begin
                @(negedge clk);
                if (tgl) begin
                    checks++;
                    if (rdma_ready !== dp_ready) begin
                        errors++;
                        $display("FAIL ready_mirror got %b want %b", rdma_ready, dp_ready);
                    end
                end
                if (rdma_ready) break;
                t++;
                if (t > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_timeout got no handshake want handshake");
                    break;
                end
                tick();
                if (tgl) dp_ready = ~dp_ready;
            end
        end
        tick();
        wdma_done = 0;
        dp_ready = 1;
        rdma_pd = {$urandom, $urandom, $urandom};
        rdma_pd[TP+14:TP+8] = 7'h00;
        rdma_valid = last;
    endtask

    task automatic finish_layer(input bit grp, input int wd_delay, input int lat_exp, input string nm);
        int lat = 0;
        if (wd_delay > 0) begin
            repeat (wd_delay - 1) tick();
            wdma_done = 1;
            tick();
            wdma_done = 0;
        end
        do begin @(negedge clk); lat++; end while (!done && lat < 60);
        checks++;
        if (done !== 1'b1 || (lat_exp > 0 && lat != lat_exp)) begin
            errors++;
            $display("FAIL %s_done_latency got %0d want %0d", nm, lat, lat_exp);
        end
        if (grp) d1 = 0;
        else d0 = 0;
        tick();
        rdma_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        rdma_valid = 1;
        d0 = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({dp_valid, rdma_ready, dp_op_en, cons, done, clr, wdog_err} !== 8'h00 || beat_num !== '0) begin
            errors++;
            $display("FAIL reset_state got %b%b%b%b%b%b%b beat=%0d want all 0",
                     dp_valid, rdma_ready, dp_op_en, cons, done, clr, wdog_err, beat_num);
        end
        d0 = 0;
        rdma_valid = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_back_to_back();
        checks++;
        if (cons !== 1'b0) begin errors++; $display("FAIL b2b_consumer0 got %b want 0", cons); end
        d0 = 1;
        d1 = 1;
        exp_done.push_back('{3, 1'b0});
        start_layer("b2b0");
        send_beats(3, 1, 0, 0);
        finish_layer(0, 3, 1, "b2b0");
        exp_done.push_back('{4, 1'b1});
        start_layer("b2b1");
        send_beats(4, 1, 0, 0);
        finish_layer(1, 3, 1, "b2b1");
    endtask

    task automatic test_single();
        d0 = 1;
        exp_done.push_back('{5, 1'b0});
        start_layer("single");
        send_beats(5, 1, 0, 0);
        finish_layer(0, 3, 1, "single");
    endtask

    task automatic test_backpressure();
        d1 = 1;
        exp_done.push_back('{8, 1'b1});
        start_layer("bp");
        send_beats(8, 1, 1, 0);
        finish_layer(1, 2, 1, "bp");
    endtask

    task automatic test_early_done();
        d0 = 1;
        exp_done.push_back('{4, 1'b0});
        start_layer("early");
        send_beats(4, 1, 0, 1);
        finish_layer(0, 0, 2, "early");
    endtask

    task automatic test_reset_mid();
        d1 = 1;
        start_layer("mid");
        send_beats(2, 0, 0, 0);
        rdma_valid = 1;
        rst = 1;
        #1;
        checks++;
        if ({dp_valid, rdma_ready, dp_op_en, cons, done, clr, wdog_err} !== 8'h00 || beat_num !== '0) begin
            errors++;
            $display("FAIL reset_mid got %b%b%b%b%b%b%b beat=%0d want all 0",
                     dp_valid, rdma_ready, dp_op_en, cons, done, clr, wdog_err, beat_num);
        end
        rdma_valid = 0;
        d1 = 0;
        d0 = 1;
        tick();
        rst = 0;
        exp_done.push_back('{3, 1'b0});
        start_layer("restart");
        send_beats(3, 1, 0, 0);
        finish_layer(0, 2, 1, "restart");
    endtask

    task automatic test_wdog();
        limit = 16'd10;
        d1 = 1;
        exp_done.push_back('{2, 1'b1});
        start_layer("wdog");
        send_beats(2, 1, 0, 0);
`ifdef CDP_LAYER_SCHED_WDOG_EN
        finish_layer(1, -1, 0, "wdog");
        repeat (5) @(negedge clk);
        checks++;
        if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_err_sticky got %b want 1", wdog_err); end
`else
        repeat (30) @(negedge clk);
        checks++;
        if (dp_op_en !== 1'b1 || done !== 1'b0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_hold got op_en=%b done=%b err=%b want 1 0 0", dp_op_en, done, wdog_err);
        end
        tick();
        finish_layer(1, 1, 1, "wdog");
        checks++;
        if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_err_off got %b want 0", wdog_err); end
`endif
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_back_to_back();
        test_single();
        test_backpressure();
        test_early_done();
        test_reset_mid();
        test_wdog();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_done.size() != 0 || exp_pd.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got done=%0d pd=%0d want 0 0", exp_done.size(), exp_pd.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
